// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci LFSR with seed load, counted bursts and wrap detection
// Optional all-zero lockup recovery: define LFSR_LOCKUP_RECOVER_EN.
module lfsr_gen #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = 7'h60,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] nsteps,
  output logic [WIDTH:1]   data_out,
  output logic             bit_out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             lockup
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           fsm_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, stepped;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, wrap_q, lockup_q;
  logic             do_step, recover;

  // Internal bit k-1 holds stage k, so TAPS applies directly as a mask.
  always_comb stepped = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

  always_comb begin
    do_step = 1'b0;
    unique case (fsm_q)
      S_RUN:   do_step = 1'b1;
      S_IDLE:  do_step = en && !(start && (nsteps == '0));
      default: do_step = en;
    endcase
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign recover = (lfsr_q == '0) && !load;
`else
  assign recover = 1'b0;
`endif

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = seed_in;
    else if (recover) lfsr_d = SEED;
    else if (do_step) lfsr_d = stepped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= SEED;
      fsm_q    <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      wrap_q   <= !load && !recover && do_step && (stepped == SEED);
      lockup_q <= recover;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      if (load) begin
        // A load aborts any burst silently: no done pulse.
        fsm_q <= S_IDLE;
        cnt_q <= '0;
      end else begin
        unique case (fsm_q)
          S_IDLE: begin
            if (start) begin
              if (nsteps != '0) begin
                fsm_q  <= S_RUN;
                cnt_q  <= nsteps;
                busy_q <= 1'b1;
              end else begin
                fsm_q  <= S_DONE;
                done_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              fsm_q  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end
          default: fsm_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out = lfsr_q;
  assign bit_out  = lfsr_q[WIDTH-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - scoreboard bench for lfsr_gen against an orbit-index reference model
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, en, load, start;
  logic [6:0] seed_in;
  logic [7:0] nsteps;
  logic [7:1] data_out;
  logic       bit_out, busy, done, wrap, lockup;

  lfsr_gen dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .start(start), .nsteps(nsteps), .data_out(data_out), .bit_out(bit_out),
    .busy(busy), .done(done), .wrap(wrap), .lockup(lockup)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          wrap_cnt = 0;
  int          seq [127];
  logic [11:0] exp_q [$];

  // Reference model: position in the 127-long orbit of SEED, -1 for the all-zero state.
  int m_idx = 0;
  int m_mode = 0;   // 0 idle, 1 run, 2 done
  int m_rem = 0;

  function automatic int idx_of(input int v);
    for (int i = 0; i < 127; i++)
      if (seq[i] == v) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [6:0] sd,
                     input logic s, input logic [7:0] n, input logic e);
    logic       st, w, lk;
    logic [6:0] ed;
    @(posedge clk);
    #2;
    rst = r; load = l; seed_in = sd; start = s; nsteps = n; en = e;
    st = 1'b0; w = 1'b0; lk = 1'b0;
    if (r) begin
      m_idx = 0; m_mode = 0; m_rem = 0;
    end else if (l) begin
      m_idx = idx_of(int'(sd)); m_mode = 0; m_rem = 0;
    end else begin
      case (m_mode)
        0: if (s && n != 0) begin m_mode = 1; m_rem = n; st = e; end
           else if (s) m_mode = 2;
           else st = e;
        1: begin st = 1'b1; m_rem--; if (m_rem == 0) m_mode = 2; end
        default: begin st = e; m_mode = 0; end
      endcase
      if (m_idx < 0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
        m_idx = 0; lk = 1'b1;
`endif
      end else if (st) begin
        m_idx = (m_idx + 1) % 127;
        w = (m_idx == 0);
      end
    end
    ed = (m_idx < 0) ? 7'd0 : 7'(seq[m_idx]);
    exp_q.push_back({ed, ed[6], m_mode == 1, m_mode == 2, w, lk});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    logic [11:0] e, g;
    #1;
    if (wrap) wrap_cnt++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = {data_out, bit_out, busy, done, wrap, lockup};
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got data=%h bit=%b busy=%b done=%b wrap=%b lockup=%b, expected data=%h bit=%b busy=%b done=%b wrap=%b lockup=%b",
                 $time, g[11:5], g[4], g[3], g[2], g[1], g[0], e[11:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    int s;
    rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; seed_in = '0; nsteps = '0;
    s = 1;
    for (int i = 0; i < 127; i++) begin
      seq[i] = s;
      s = ((s << 1) & 127) | (((s >> 6) ^ (s >> 5)) & 1);
    end

    // Free-run from reset: 01 02 04 08 10 20 41.
    cyc(1, 0, 0, 0, 0, 0);
    idle();
    chk("reset_data", 32'(data_out), 32'h01);
    chk("reset_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1);
    idle();
    chk("seq_step6", 32'(data_out), 32'h41);
    chk("bit_step6", 32'(bit_out), 32'd1);

    // Full period: exactly one wrap, on return to SEED.
    cyc(1, 0, 0, 0, 0, 0);
    wrap_cnt = 0;
    for (int i = 0; i < 127; i++) cyc(0, 0, 0, 0, 0, 1);
    idle();
    chk("period_data", 32'(data_out), 32'h01);
    chk("period_wraps", 32'(wrap_cnt), 32'd1);

    // Burst of 5 with en held high during RUN.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    idle();
    chk("burst5_data", 32'(data_out), 32'h20);
    chk("burst5_done", 32'(done), 32'd1);
    chk("burst5_busy", 32'(busy), 32'd0);
    idle();
    chk("burst5_done_once", 32'(done), 32'd0);

    // Load aborts a burst of 10; then a zero-length burst.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 10, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 7'h7f, 0, 0, 0);
    idle();
    chk("abort_data", 32'(data_out), 32'h7f);
    chk("abort_busy", 32'(busy), 32'd0);
    idle();
    chk("abort_no_done", 32'(done), 32'd0);
    cyc(0, 0, 0, 1, 0, 1);
    idle();
    chk("zero_burst_done", 32'(done), 32'd1);
    chk("zero_burst_data", 32'(data_out), 32'h7f);

    // All-zero state handling.
    cyc(0, 1, 7'h00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle();
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("lockup_data", 32'(data_out), 32'h01);
    chk("lockup_pulse", 32'(lockup), 32'd1);
`else
    chk("lockup_data", 32'(data_out), 32'h00);
    chk("lockup_pulse", 32'(lockup), 32'd0);
`endif

    // Reset mid-burst with load and start asserted.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 7'h55, 1, 3, 1);
    idle();
    chk("rst_mid_data", 32'(data_out), 32'h01);
    chk("rst_mid_flags", 32'({busy, done, wrap}), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      logic [6:0] sd;
      sd = 7'($urandom);
      if ($urandom_range(0, 3) == 0) sd = '0;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, sd,
          $urandom_range(0, 7) == 0, 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    end
    idle();
    idle();
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR: configurable width, tap mask and reset seed.
- Adds three things beyond a fixed-width free-running generator: runtime seed load, a counted burst mode with start/busy/done handshake, and sequence wrap detection.
- Feeds pseudo-random delays and patterns to the F1-light timing logic and test pattern generators.

Parameters:
- WIDTH, 7: LFSR length in stages; legal range 3..32.
- TAPS, 7'h60: feedback mask, WIDTH bits; bit k-1 set means stage k is tapped. Default gives x^7+x^6+1, primitive, period 127.
- SEED, 1: state loaded on reset; must be non-zero.
- CNT_W, 8: width of the burst step count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  free-run step enable; honoured only when idle.
- load  in  1  load seed_in into the state this cycle.
- seed_in  in  WIDTH  value loaded on load.
- start  in  1  begin a counted burst; sampled only when idle.
- nsteps  in  CNT_W  number of steps in the burst.
- data_out  out  [WIDTH:1]  current LFSR state.
- bit_out  out  1  serial output, equal to state stage WIDTH.
- busy  out  1  high while a burst runs.
- done  out  1  one-cycle pulse when a burst completes.
- wrap  out  1  one-cycle pulse when a step lands on SEED.
- lockup  out  1  one-cycle pulse on all-zero recovery (see Optional Feature).

Behaviour:
- Step definition:
  - state[k] <= state[k-1] for k = 2..WIDTH.
  - state[1] <= XOR over k of (state[k] & TAPS[k-1]).
  - The old stage WIDTH bit is dropped.
- Reset: data_out=SEED, busy=0, done=0, wrap=0, lockup=0, FSM=IDLE, step counter=0.
- Priority each cycle: rst > load > burst step > en step.
- All outputs are registered; a step is visible on data_out the cycle after the enabling edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - start=1, nsteps!=0: load counter=nsteps, go to RUN. No step this cycle unless en=1, in which case one free-run step also occurs.
    - start=1, nsteps=0: go to DONE, no step.
    - Otherwise: step if en=1.
  - RUN:
    - busy=1; one step every cycle; en ignored; counter decrements.
    - When counter=1 at the edge: perform the final step, go to DONE.
    - Exactly nsteps steps occur in RUN.
  - DONE: done=1, busy=0 for one cycle, then IDLE. en is honoured in DONE.
- start while busy or in DONE: ignored.
- load at any time:
  - state <= seed_in.
  - If in RUN: abort to IDLE, busy drops next cycle, no done pulse.
  - load suppresses any step that cycle.
- wrap: registered; high for one cycle after a step (free-run or burst) whose result equals SEED. Not raised by reset or load, even when seed_in equals SEED.
- rst mid-burst: immediate return to IDLE, outputs to reset values, no done pulse.

Optional Feature:
- Macro: LFSR_LOCKUP_RECOVER_EN.
- Defined:
  - If the state is all-zero at any edge (only reachable via load of 0), the state is replaced by SEED at that edge instead of stepping or holding.
  - lockup pulses for one cycle, coincident with data_out showing SEED.
  - A burst in progress continues; the recovery edge counts as a step.
  - load has priority over recovery that cycle.
- Undefined:
  - All-zero state is retained (steps map 0 to 0).
  - lockup tied to 0.

Test Plan:
- Reset, then en=1 for 7 cycles with default params -> data_out sequence 01, 02, 04, 08, 10, 20, 41 (hex); bit_out=1 after step 6.
- en=1 held 127 cycles from reset -> wrap pulses exactly once, on the cycle data_out returns to 01; no repeat of any earlier state before that.
- Idle, start=1, nsteps=5 -> busy high 5 cycles, data_out steps 5 times to 20; done pulses once; busy low on the done cycle; en=1 during RUN causes no extra steps.
- Burst nsteps=10, load=1 with seed_in=7F at the 3rd RUN cycle -> data_out=7F next cycle, busy low, no done pulse; start with nsteps=0 -> done next cycle, data_out unchanged.
- With LFSR_LOCKUP_RECOVER_EN defined: load seed_in=00, then en=1 -> data_out 00 for one cycle, then 01 with lockup=1. Without the macro: data_out stays 00 and lockup stays 0.
- rst asserted mid-burst together with load and start -> next cycle data_out=01, busy=0, done=0, wrap=0.
